// File: rtl/vdp_arb_pkg.sv
// Shared types and constants for the two-master VDP host-port arbiter.
package vdp_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} arb_state_t;
  typedef enum logic {GRANT_M0, GRANT_M1} grant_t;

  // One host-port request as it is presented to the VDP.
  typedef struct packed {
    logic              sel;
    logic              rnw;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] di;
    logic              uds_n;
    logic              lds_n;
  } host_req_t;

  // Registered response returned to one master.
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              dtack_n;
    logic              err;
  } host_rsp_t;

  localparam host_req_t REQ_IDLE = '{sel: 1'b0, rnw: 1'b1, a: '0, di: '0,
                                     uds_n: 1'b1, lds_n: 1'b1};
  localparam host_rsp_t RSP_IDLE = '{rdata: '0, dtack_n: 1'b1, err: 1'b0};

endpackage

// File: rtl/vdp_host_if.sv
// 68k-style host bus: the master drives the request, the slave answers with data and DTACK.
interface vdp_host_if;
  import vdp_arb_pkg::*;

  logic              sel;
  logic              rnw;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] di;
  logic              uds_n;
  logic              lds_n;
  logic [DATA_W-1:0] rdata;
  logic              dtack_n;
  logic              err;

  modport master (output sel, rnw, a, di, uds_n, lds_n,
                  input  rdata, dtack_n, err);
  modport slave  (input  sel, rnw, a, di, uds_n, lds_n,
                  output rdata, dtack_n, err);
endinterface

// File: rtl/vdp_arb_pick.sv
// Two-way winner select: fixed M0 priority or round-robin against the last grant.
module vdp_arb_pick
  import vdp_arb_pkg::*;
(
  input  logic   m0_sel,
  input  logic   m1_sel,
  input  logic   m0_priority,
  input  grant_t last_grant,
  output grant_t winner
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    winner = GRANT_M0;
    if (m1_sel && !m0_sel) begin
      winner = GRANT_M1;
    end else if (m0_sel && m1_sel && !m0_priority) begin
      winner = (last_grant == GRANT_M0) ? GRANT_M1 : GRANT_M0;
    end
  end

endmodule

// File: rtl/vdp_host_arbiter.sv
// Shares the single VDP host port between the init sequencer (M0) and the CPU bus (M1),
// with a per-cycle DTACK timeout so a silent VDP cannot hold the port forever.
module vdp_host_arbiter
  import vdp_arb_pkg::*;
#(
  parameter  int TIMEOUT = 64,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_priority,
  vdp_host_if.slave  m0,
  vdp_host_if.slave  m1,
  vdp_host_if.master vdp
);

  arb_state_t       state_q, state_d;
  grant_t           grant_q, grant_d;
  grant_t           last_q, last_d;
  grant_t           winner;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  host_req_t        vdp_q, vdp_d;
  host_rsp_t        rsp_q [2];
  host_rsp_t        rsp_d [2];
  host_req_t        req   [2];
  logic             ack;
  logic             timed_out;

  assign req[0] = '{sel: m0.sel, rnw: m0.rnw, a: m0.a, di: m0.di,
                    uds_n: m0.uds_n, lds_n: m0.lds_n};
  assign req[1] = '{sel: m1.sel, rnw: m1.rnw, a: m1.a, di: m1.di,
                    uds_n: m1.uds_n, lds_n: m1.lds_n};

  vdp_arb_pick u_pick (
    .m0_sel      (m0.sel),
    .m1_sel      (m1.sel),
    .m0_priority (m0_priority),
    .last_grant  (last_q),
    .winner      (winner)
  );

  assign ack       = ~vdp.dtack_n;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    vdp_d   = vdp_q;
    rsp_d   = rsp_q;

    unique case (state_q)
      IDLE: begin
        if (req[0].sel || req[1].sel) begin
          vdp_d     = req[winner];
          vdp_d.sel = 1'b1;
          grant_d   = winner;
          cnt_d     = '0;
          state_d   = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        // A real ack wins over a timeout landing on the same cycle.
        if (ack || timed_out) begin
          vdp_d.sel = 1'b0;
          if (vdp_q.rnw) begin
            rsp_d[grant_q].rdata = ack ? vdp.rdata : TIMEOUT_DATA;
          end
          rsp_d[grant_q].dtack_n = 1'b0;
          rsp_d[grant_q].err     = ~ack;
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RELEASE: begin
        if (!req[grant_q].sel) begin
          rsp_d[grant_q].dtack_n = 1'b1;
          rsp_d[grant_q].err     = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: reset is sampled on the clock edge only, so it sits inside the clocked branch.
  // NOTE: clocked state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= GRANT_M0;
      last_q   <= GRANT_M1;
      cnt_q    <= '0;
      vdp_q    <= REQ_IDLE;
      rsp_q[0] <= RSP_IDLE;
      rsp_q[1] <= RSP_IDLE;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      vdp_q    <= vdp_d;
      rsp_q[0] <= rsp_d[0];
      rsp_q[1] <= rsp_d[1];
    end
  end

  assign vdp.sel   = vdp_q.sel;
  assign vdp.rnw   = vdp_q.rnw;
  assign vdp.a     = vdp_q.a;
  assign vdp.di    = vdp_q.di;
  assign vdp.uds_n = vdp_q.uds_n;
  assign vdp.lds_n = vdp_q.lds_n;

  assign m0.rdata   = rsp_q[0].rdata;
  assign m0.dtack_n = rsp_q[0].dtack_n;
  assign m0.err     = rsp_q[0].err;
  assign m1.rdata   = rsp_q[1].rdata;
  assign m1.dtack_n = rsp_q[1].dtack_n;
  assign m1.err     = rsp_q[1].err;

endmodule
